mac_bank_ctrl: RTL and testbench

MAC_BANK_CTRL -- requirements
Module: mac_bank_ctrl

---
 rtl/mac_bank_ctrl.sv | 101 ++++++++++
 tb/tb_mac_bank_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mac_bank_ctrl.sv
// mac_bank_ctrl: sequences operand reads, MAC enables and tile result handoff for a POX-lane MAC bank
module mac_bank_ctrl #(
   parameter int DW   = 32,
   parameter int POX  = 3,
   parameter int NMAX = 9,
   parameter int AW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       n_tiles,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [AW-1:0]     rd_addr,
   output logic              mac_ena,
   input  logic [POX-1:0]    mac_cnt_c,
   input  logic [POX*DW-1:0] mac_result,
   output logic [POX*DW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       tile_idx
);
   localparam int CW = (NMAX > 1) ? $clog2(NMAX) : 1;
   typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_OUT, S_FIN} state_t;
   state_t state_q, state_d;
   logic [15:0] n_q, n_d, tile_q, tile_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic valid_q, valid_d, mac_ena_q;
   logic [POX*DW-1:0] data_q, data_d;
   logic last_rd, more_tiles;
   assign last_rd    = cnt_q == CW'(NMAX - 1);
   assign more_tiles = ({1'b0, tile_q} + 17'd1) < {1'b0, n_q};
   assign busy       = state_q != S_IDLE;
   assign done       = state_q == S_FIN;
   assign rd_en      = state_q == S_FEED;
   assign rd_addr    = addr_q;
   assign mac_ena    = mac_ena_q;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign tile_idx   = tile_q;
   // state and datapath registers; reset drops any partial tile
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         tile_q    <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         mac_ena_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         tile_q    <= tile_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         mac_ena_q <= rd_en;
      end
   end
   // next-state: feed NMAX reads, wait for all lanes, hand off the tile, repeat or finish
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      tile_d  = tile_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: if (start) begin
            n_d     = n_tiles;
            tile_d  = '0;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = (n_tiles != 16'd0) ? S_FEED : S_FIN;
         end
         S_FEED: begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = last_rd ? '0 : cnt_q + 1'b1;
            state_d = last_rd ? S_WAIT : S_FEED;
         end
         S_WAIT: if (&mac_cnt_c) begin
            data_d  = mac_result;
            valid_d = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: if (valid_q && out_ready) begin
            valid_d = 1'b0;
            tile_d  = tile_q + 16'd1;
            state_d = more_tiles ? S_FEED : S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_mac_bank_ctrl.sv
// tb_mac_bank_ctrl: directed and randomized jobs checked against an address/result reference model
module tb_mac_bank_ctrl;
   localparam int DW = 32, POX = 3, NMAX = 9, AW = 16;
   logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
   logic [15:0] n_tiles = '0;
   logic busy, done, rd_en, mac_ena, out_valid;
   logic [AW-1:0] rd_addr;
   logic [POX-1:0] mac_cnt_c = '0;
   logic [POX*DW-1:0] mac_result = '0, out_data;
   logic [15:0] tile_idx;
   int n_cmp = 0, n_bad = 0;
   int mac_n = 0, done_n = 0, hs_n = 0;
   logic [AW-1:0] addr_log[$];

   mac_bank_ctrl #(.DW(DW), .POX(POX), .NMAX(NMAX), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_tiles(n_tiles), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .mac_ena(mac_ena), .mac_cnt_c(mac_cnt_c),
      .mac_result(mac_result), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .tile_idx(tile_idx)
   );

   always #5 clk = ~clk;

   // observe activity of each completed cycle
   always @(posedge clk) begin
      if (rd_en) addr_log.push_back(rd_addr);
      if (mac_ena) mac_n++;
      if (done) done_n++;
      if (out_valid && out_ready) hs_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      addr_log.delete();
      mac_n = 0;
      done_n = 0;
      hs_n = 0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_mac_ena"}, mac_ena, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_tile_idx"}, tile_idx, 0);
   endtask

   // one whole job: n tiles, per-tile ready delay up to dmax, optional partial lane completion,
   // optional start pulse mid-job, optional mac_cnt_c noise during FEED
   task automatic run_job(input int n, input int dmax, input bit partial, input bit poke, input bit noise);
      logic [POX*DW-1:0] exp_data;
      int d;
      clr();
      start = 1;
      n_tiles = 16'(n);
      tick();
      chk("first_rd_en", rd_en, 1);
      chk("first_rd_addr", rd_addr, 0);
      start = 0;
      if (poke) begin
         start = 1;
         n_tiles = 16'd7;
         tick();
         start = 0;
      end
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < 200 && mac_n < (t + 1) * NMAX; i++) begin
            mac_cnt_c = (noise && rd_en) ? POX'($urandom) : '0;
            tick();
         end
         mac_cnt_c = '0;
         chk("mac_ena_count", mac_n, (t + 1) * NMAX);
         chk("rd_en_after_feed", rd_en, 0);
         tick();
         tick();
         if (partial) begin
            mac_cnt_c = {1'b0, {(POX - 1){1'b1}}};
            repeat (4) begin
               tick();
               chk("partial_no_valid", out_valid, 0);
               chk("partial_busy", busy, 1);
            end
         end
         exp_data = {$urandom, $urandom, $urandom};
         mac_result = exp_data;
         mac_cnt_c = '1;
         d = $urandom_range(0, dmax);
         out_ready = (d == 0);
         tick();
         mac_cnt_c = '0;
         mac_result = '0;
         chk("out_valid_rise", out_valid, 1);
         chk("out_data", out_data, exp_data);
         chk("tile_idx", tile_idx, t);
         repeat (d) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp_data);
            chk("bp_no_rd", rd_en, 0);
         end
         out_ready = 1;
         tick();
         out_ready = 0;
         chk("out_valid_drop", out_valid, 0);
         chk("tile_idx_inc", tile_idx, t + 1);
         chk("hs_count", hs_n, t + 1);
         if (t < n - 1) begin
            chk("next_rd_en", rd_en, 1);
            chk("next_rd_addr", rd_addr, AW'((t + 1) * NMAX));
         end else begin
            chk("done_pulse", done, 1);
         end
      end
      tick();
      chk("done_low", done, 0);
      chk("busy_low", busy, 0);
      chk("done_count", done_n, 1);
      chk("addr_count", addr_log.size(), n * NMAX);
      for (int k = 0; k < addr_log.size(); k++) begin
         logic [AW-1:0] ea;
         ea = AW'(k);
         if (addr_log[k] !== ea) chk("addr_seq", addr_log[k], ea);
      end
   endtask

   initial begin
      tick();
      tick();
      chk_idle_outputs("reset");
      rst_n = 1;
      tick();
      run_job(1, 0, 0, 0, 0);
      run_job(3, 0, 0, 1, 0);
      run_job(2, 5, 0, 0, 0);
      run_job(1, 0, 1, 0, 0);
      clr();
      start = 1;
      n_tiles = 16'd0;
      tick();
      start = 0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      tick();
      chk("zero_done_low", done, 0);
      chk("zero_busy_low", busy, 0);
      chk("zero_no_rd", addr_log.size(), 0);
      chk("zero_no_mac", mac_n, 0);
      clr();
      start = 1;
      n_tiles = 16'd2;
      tick();
      start = 0;
      for (int i = 0; i < 50 && addr_log.size() < 3; i++) tick();
      chk("rst_rd_en", rd_en, 1);
      chk("rst_rd_addr", rd_addr, 3);
      rst_n = 0;
      #1;
      chk_idle_outputs("async_rst");
      tick();
      tick();
      rst_n = 1;
      chk("rst_no_done", done_n, 0);
      tick();
      run_job(1, 0, 0, 0, 0);
      for (int r = 0; r < 4; r++)
         run_job($urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
